// File: rtl/vend_txn_controller.sv
// vend_txn_controller
// Vending transaction sequencer: collects coin credit, requests a dispense,
// and returns change or refunds through the change-dispenser handshake.
// Covers cancel, inactivity timeout and coin rejection. Every output is
// registered. The next-state logic computes the next value of every
// register, and one flop block captures them all.

module vend_txn_controller #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 255,
  parameter int TMR_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic                chg_req,
  output logic [CREDIT_W-1:0] chg_amt,
  output logic                product,
  output logic                change,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COLLECT  = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam logic [1:0] S_RETURN   = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]          state, state_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [CREDIT_W-1:0] credit_n, chg_amt_n;
  logic                disp_req_n, chg_req_n;
  logic                product_n, change_n, coin_rej_n, busy_n;

  // The 11 encoding is never worth credit. It is treated as "no coin"
  // everywhere except the reject pulse.
  logic                coin_ok;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] remainder;

  // Decode the coin value, the running sum and the post-sale remainder.
  always_comb begin
    coin_ok   = (coin == 2'b01) || (coin == 2'b10);
    coin_val  = coin_ok ? CREDIT_W'(coin) : '0;
    sum       = credit + coin_val;
    remainder = credit - PRICE_C;
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    credit_n   = credit;
    chg_amt_n  = chg_amt;
    disp_req_n = disp_req;
    chg_req_n  = chg_req;
    product_n  = 1'b0;
    change_n   = 1'b0;
    coin_rej_n = (coin == 2'b11);

    case (state)
      S_IDLE: begin
        // cancel has no meaning without credit, so it is ignored here.
        if (coin_ok) begin
          credit_n = coin_val;
          timer_n  = '0;
          if (coin_val >= PRICE_C) begin
            state_n    = S_DISPENSE;
            disp_req_n = 1'b1;
          end else begin
            state_n = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (cancel) begin
          // cancel beats a coin in the same cycle. The coin bounces and
          // the refund is the credit held before this edge.
          coin_rej_n = (coin != 2'b00);
          state_n    = S_RETURN;
          chg_amt_n  = credit;
          chg_req_n  = 1'b1;
          timer_n    = '0;
        end else if (coin_ok) begin
          credit_n = sum;
          timer_n  = '0;
          if (sum >= PRICE_C) begin
            state_n    = S_DISPENSE;
            disp_req_n = 1'b1;
          end
        end else if (timer == TMR_LAST) begin
          // TIMEOUT idle edges since the last coin: refund automatically.
          state_n   = S_RETURN;
          chg_amt_n = credit;
          chg_req_n = 1'b1;
          timer_n   = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      S_DISPENSE: begin
        coin_rej_n = (coin != 2'b00);
        if (disp_ack) begin
          disp_req_n = 1'b0;
          product_n  = 1'b1;
          credit_n   = remainder;
          if (remainder != '0) begin
            state_n   = S_RETURN;
            chg_amt_n = remainder;
            chg_req_n = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      S_RETURN: begin
        coin_rej_n = (coin != 2'b00);
        if (chg_ack) begin
          chg_req_n = 1'b0;
          change_n  = 1'b1;
          credit_n  = '0;
          chg_amt_n = '0;
          state_n   = S_IDLE;
        end
      end

      default: begin
        state_n    = S_IDLE;
        credit_n   = '0;
        chg_amt_n  = '0;
        disp_req_n = 1'b0;
        chg_req_n  = 1'b0;
        timer_n    = '0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // Register the state and all outputs. The async reset clears them at once
  // and drops any credit held at that moment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      timer    <= '0;
      credit   <= '0;
      chg_amt  <= '0;
      disp_req <= 1'b0;
      chg_req  <= 1'b0;
      product  <= 1'b0;
      change   <= 1'b0;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      credit   <= credit_n;
      chg_amt  <= chg_amt_n;
      disp_req <= disp_req_n;
      chg_req  <= chg_req_n;
      product  <= product_n;
      change   <= change_n;
      coin_rej <= coin_rej_n;
      busy     <= busy_n;
    end
  end

endmodule
